// File: rtl/branch_ctrl_if.sv
// Decode-to-branch-controller bundle: instruction handshake and operands in;
// redirect, link, flush, misalign and statistics out.
interface branch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             kill;
  logic             cnt_clr;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush;
  logic             link_valid;
  logic [XLEN-1:0]  link_data;
  logic             misalign_err;
  logic [XLEN-1:0]  err_pc;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1_data, rs2_data,
           kill, cnt_clr,
    input  in_ready, redirect_valid, redirect_pc, flush, link_valid, link_data,
           misalign_err, err_pc, br_count, taken_count
  );

  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1_data, rs2_data,
           kill, cnt_clr,
    output in_ready, redirect_valid, redirect_pc, flush, link_valid, link_data,
           misalign_err, err_pc, br_count, taken_count
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/jump resolution: outcome one cycle after accept, then redirect + fixed flush.
// One instruction in flight; in_ready is high only in IDLE.
module branch_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic          clk,
  input logic          rst_n,
  branch_ctrl_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;
  typedef enum logic [1:0] {CLS_BR, CLS_JAL, CLS_JALR} cls_t;

  state_t          state;
  cls_t            cls_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [FC_W-1:0] flush_cnt;

  logic            accept;
  logic            br_taken;
  logic            taken;
  logic            misal;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.kill;

  always_comb begin
    br_taken = 1'b0;
    case (funct3_q)
      3'b000:  br_taken = (rs1_q == rs2_q);
      3'b001:  br_taken = (rs1_q != rs2_q);
      3'b100:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_taken = (rs1_q <  rs2_q);
      3'b111:  br_taken = (rs1_q >= rs2_q);
      default: br_taken = 1'b0;
    endcase
  end

  assign taken    = (cls_q != CLS_BR) | br_taken;
  assign jalr_sum = rs1_q + imm_q;
  assign target   = (cls_q == CLS_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
  assign misal    = |target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cls_q              <= CLS_BR;
      funct3_q           <= '0;
      pc_q               <= '0;
      imm_q              <= '0;
      rs1_q              <= '0;
      rs2_q              <= '0;
      flush_cnt          <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush          <= 1'b0;
      bus.link_valid     <= 1'b0;
      bus.link_data      <= '0;
      bus.misalign_err   <= 1'b0;
      bus.err_pc         <= '0;
      bus.br_count       <= '0;
      bus.taken_count    <= '0;
    end else begin
      bus.redirect_valid <= 1'b0;
      bus.link_valid     <= 1'b0;
      bus.misalign_err   <= 1'b0;

      if (bus.kill) begin
        // Abort wins everywhere: pending pulses die and counters are not touched.
        state     <= IDLE;
        bus.flush <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && (bus.is_branch || bus.is_jal || bus.is_jalr)) begin
              if (bus.is_jalr)     cls_q <= CLS_JALR;
              else if (bus.is_jal) cls_q <= CLS_JAL;
              else                 cls_q <= CLS_BR;
              funct3_q <= bus.funct3;
              pc_q     <= bus.pc;
              imm_q    <= bus.imm;
              rs1_q    <= bus.rs1_data;
              rs2_q    <= bus.rs2_data;
              state    <= EVAL;
            end
          end
          EVAL: begin
            if (taken && !misal) begin
              state              <= REDIRECT;
              bus.redirect_valid <= 1'b1;
              bus.redirect_pc    <= target;
              bus.flush          <= 1'b1;
              if (cls_q != CLS_BR) begin
                bus.link_valid <= 1'b1;
                bus.link_data  <= pc_q + XLEN'(4);
              end
            end else begin
              state <= IDLE;
              if (taken) begin
                bus.misalign_err <= 1'b1;
                bus.err_pc       <= pc_q;
              end
            end
            if (cls_q == CLS_BR) begin
              bus.br_count <= bus.br_count + CNT_W'(1);
              if (taken) bus.taken_count <= bus.taken_count + CNT_W'(1);
            end
          end
          REDIRECT: begin
            state     <= FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
          end
          FLUSH: begin
            if (flush_cnt == '0) begin
              state     <= IDLE;
              bus.flush <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Clear overrides any increment scheduled above in the same cycle.
      if (bus.cnt_clr) begin
        bus.br_count    <= '0;
        bus.taken_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: stimulus pushes expected redirect/misalign events,
// a negedge monitor pops and compares them; timing and counters are checked inline.
module tb_branch_ctrl;
  localparam int XLEN  = 32;
  localparam int FC    = 2;
  localparam int CNT_W = 4;  // narrow counters so wrap-around is reachable quickly

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [CNT_W-1:0] exp_br = '0;
  logic [CNT_W-1:0] exp_tk = '0;
  logic [31:0]      tpc;

  typedef struct {
    bit          mis;
    logic [31:0] addr;
    bit          link;
    logic [31:0] ldat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [2:0]  t_f3 [9] = '{3'b001, 3'b001, 3'b100, 3'b101, 3'b101, 3'b111, 3'b110, 3'b010, 3'b000};
  logic [31:0] t_a  [9] = '{32'd5, 32'd5, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 32'd7, 32'd1};
  logic [31:0] t_b  [9] = '{32'd5, 32'd6, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd2};
  bit          t_tk [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  branch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_br_count"},    32'(bus.br_count),    32'(exp_br));
    chk({name, "_taken_count"}, 32'(bus.taken_count), 32'(exp_tk));
  endtask

  task automatic note_br(input bit tk);
    exp_br = exp_br + 1'b1;
    if (tk) exp_tk = exp_tk + 1'b1;
  endtask

  task automatic push_redir(input logic [31:0] a, input bit lk, input logic [31:0] ld);
    exp_t e;
    e.mis = 1'b0; e.addr = a; e.link = lk; e.ldat = ld;
    sb.push_back(e);
  endtask

  task automatic push_mis(input logic [31:0] a);
    exp_t e;
    e.mis = 1'b1; e.addr = a; e.link = 1'b0; e.ldat = '0;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Presents one instruction for exactly one accept edge; returns 1 time unit into cycle 0.
  task automatic send(input bit jr, input bit j, input bit b, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] im,
                      input logic [31:0] a, input logic [31:0] bb);
    wait_idle("send");
    bus.in_valid  = 1'b1;
    bus.is_jalr   = jr;
    bus.is_jal    = j;
    bus.is_branch = b;
    bus.funct3    = f3;
    bus.pc        = p;
    bus.imm       = im;
    bus.rs1_data  = a;
    bus.rs2_data  = bb;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.is_jalr   = 1'b0;
    bus.is_jal    = 1'b0;
    bus.is_branch = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.redirect_valid || bus.misalign_err || bus.link_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: redirect_valid=%0b link_valid=%0b misalign_err=%0b, none expected",
                 bus.redirect_valid, bus.link_valid, bus.misalign_err);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.mis) begin
          chk("mon_misalign_err",   32'(bus.misalign_err),   32'd1);
          chk("mon_err_pc",         bus.err_pc,              mon_e.addr);
          chk("mon_mis_no_redirect", 32'(bus.redirect_valid), 32'd0);
          chk("mon_mis_no_link",    32'(bus.link_valid),     32'd0);
          chk("mon_mis_no_flush",   32'(bus.flush),          32'd0);
        end else begin
          chk("mon_redirect_valid", 32'(bus.redirect_valid), 32'd1);
          chk("mon_redirect_pc",    bus.redirect_pc,         mon_e.addr);
          chk("mon_redirect_flush", 32'(bus.flush),          32'd1);
          chk("mon_link_valid",     32'(bus.link_valid),     32'(mon_e.link));
          if (mon_e.link) chk("mon_link_data", bus.link_data, mon_e.ldat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.is_branch = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0;
    bus.funct3 = '0; bus.pc = '0; bus.imm = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.kill = 1'b0; bus.cnt_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready",       32'(bus.in_ready),       32'd1);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_flush",          32'(bus.flush),          32'd0);
    chk("rst_link_valid",     32'(bus.link_valid),     32'd0);
    chk("rst_misalign_err",   32'(bus.misalign_err),   32'd0);
    chk("rst_redirect_pc",    bus.redirect_pc,         32'd0);
    chk("rst_link_data",      bus.link_data,           32'd0);
    chk("rst_err_pc",         bus.err_pc,              32'd0);
    chk_counts("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ taken: redirect cycle 1, flush cycles 1..3, ready in cycle 4
    push_redir(32'h120, 1'b0, 32'h0);
    note_br(1'b1);
    send(0, 0, 1, 3'b000, 32'h100, 32'h20, 32'h5, 32'h5);
    @(negedge clk); chk("beq_c0_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); chk("beq_c1_flush",    32'(bus.flush),    32'd1);
    @(negedge clk); chk("beq_c2_flush",    32'(bus.flush),    32'd1);
                    chk("beq_c2_redirect", 32'(bus.redirect_valid), 32'd0);
    @(negedge clk); chk("beq_c3_flush",    32'(bus.flush),    32'd1);
                    chk("beq_c3_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); chk("beq_c4_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("beq_c4_flush",    32'(bus.flush),    32'd0);
    chk("beq_br_count",    32'(bus.br_count),    32'd1);
    chk("beq_taken_count", 32'(bus.taken_count), 32'd1);

    // Counter clear, then signed vs unsigned compare of the same operands
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clr = 1'b0;
    exp_br = '0; exp_tk = '0;
    @(negedge clk); chk_counts("clr");
    push_redir(32'h310, 1'b0, 32'h0);
    note_br(1'b1);
    send(0, 0, 1, 3'b100, 32'h300, 32'h10, 32'hFFFFFFFF, 32'h1);
    wait_idle("blt");
    note_br(1'b0);
    send(0, 0, 1, 3'b110, 32'h300, 32'h10, 32'hFFFFFFFF, 32'h1);
    @(negedge clk);
    @(negedge clk); chk("bltu_c1_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("bltu_c1_flush",    32'(bus.flush),    32'd0);
    chk("bltu_br_count",    32'(bus.br_count),    32'd2);
    chk("bltu_taken_count", 32'(bus.taken_count), 32'd1);

    // JALR to a misaligned target
    push_mis(32'h200);
    send(1, 0, 0, 3'b000, 32'h200, 32'h4, 32'h1003, 32'h0);
    @(negedge clk);
    @(negedge clk); chk("jalr_c1_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("jalr_c1_flush",    32'(bus.flush),    32'd0);
    @(negedge clk); chk("jalr_c2_misalign", 32'(bus.misalign_err), 32'd0);
    chk_counts("jalr");

    // JAL with link
    push_redir(32'hC0, 1'b1, 32'h44);
    send(0, 1, 0, 3'b000, 32'h40, 32'h80, 32'h0, 32'h0);
    wait_idle("jal");
    chk_counts("jal");

    // All class bits set: treated as JALR
    push_redir(32'h2010, 1'b1, 32'h504);
    send(1, 1, 1, 3'b001, 32'h500, 32'h10, 32'h2000, 32'h2000);
    wait_idle("prio");
    chk_counts("prio");

    // No class bit: consumed, nothing happens
    send(0, 0, 0, 3'b000, 32'h900, 32'h4, 32'h0, 32'h0);
    @(negedge clk); chk("noclass_in_ready", 32'(bus.in_ready), 32'd1);
    chk_counts("noclass");

    // Remaining compare conditions, negative offset
    for (int i = 0; i < 9; i++) begin
      tpc = 32'h1000 + 32'(i) * 32'h40;
      if (t_tk[i]) push_redir(tpc - 32'd16, 1'b0, 32'h0);
      note_br(t_tk[i]);
      send(0, 0, 1, t_f3[i], tpc, 32'hFFFFFFF0, t_a[i], t_b[i]);
      wait_idle("tbl");
    end
    chk_counts("tbl");

    // kill during EVAL: nothing issued, counters untouched
    send(0, 0, 1, 3'b000, 32'h600, 32'h40, 32'h9, 32'h9);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    @(negedge clk); chk("kill_eval_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("kill_eval_flush",    32'(bus.flush),    32'd0);
    chk_counts("kill_eval");

    // kill during REDIRECT
    push_redir(32'h640, 1'b0, 32'h0);
    note_br(1'b1);
    send(0, 0, 1, 3'b000, 32'h600, 32'h40, 32'h9, 32'h9);
    @(posedge clk); #1;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    @(negedge clk); chk("kill_redir_flush",    32'(bus.flush),          32'd0);
                    chk("kill_redir_redirect", 32'(bus.redirect_valid), 32'd0);
                    chk("kill_redir_in_ready", 32'(bus.in_ready),       32'd1);
    chk_counts("kill_redir");

    // Async reset during FLUSH
    push_redir(32'h708, 1'b0, 32'h0);
    note_br(1'b1);
    send(0, 0, 1, 3'b000, 32'h700, 32'h8, 32'h3, 32'h3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("arst_pre_flush", 32'(bus.flush), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush",       32'(bus.flush),  32'd0);
    chk("arst_in_ready",    32'(bus.in_ready), 32'd1);
    chk("arst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("arst_br_count",    32'(bus.br_count),    32'd0);
    chk("arst_taken_count", 32'(bus.taken_count), 32'd0);
    exp_br = '0; exp_tk = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("arst_after_in_ready", 32'(bus.in_ready), 32'd1);

    // Counter wrap: 15 taken, then one more
    for (int i = 0; i < 15; i++) begin
      push_redir(32'h808, 1'b0, 32'h0);
      note_br(1'b1);
      send(0, 0, 1, 3'b000, 32'h800, 32'h8, 32'h1, 32'h1);
      wait_idle("wrap_fill");
    end
    chk("wrap_pre_taken_count", 32'(bus.taken_count), 32'hF);
    push_redir(32'h808, 1'b0, 32'h0);
    note_br(1'b1);
    send(0, 0, 1, 3'b000, 32'h800, 32'h8, 32'h1, 32'h1);
    wait_idle("wrap");
    chk("wrap_taken_count", 32'(bus.taken_count), 32'h0);
    chk("wrap_br_count",    32'(bus.br_count),    32'h0);

    // cnt_clr coincident with an increment
    note_br(1'b0);
    send(0, 0, 1, 3'b001, 32'hA00, 32'h8, 32'h4, 32'h4);
    wait_idle("pre_clr");
    chk("pre_clr_br_count", 32'(bus.br_count), 32'd1);
    push_redir(32'hA08, 1'b0, 32'h0);
    send(0, 0, 1, 3'b000, 32'hA00, 32'h8, 32'h4, 32'h4);
    bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.cnt_clr = 1'b0;
    exp_br = '0; exp_tk = '0;
    @(negedge clk); chk_counts("clr_vs_inc");
    wait_idle("clr_vs_inc");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
